data_mem_responder: RTL and testbench

Memory-side responder for the datapath's load/store port. It accepts one request at a time over a valid/ready handshake: the word address comes from the ALU result, and the write data comes from register-file read port 2. After a programmable number of wait states it returns read data, or a write acknowledge, over a second valid/ready handshake. This lets the datapath be verified against a realistic, non-zero-latency data memory.

---
 rtl/data_mem_responder_pkg.sv | 14 +
 rtl/data_mem_responder_dmem_array.sv | 31 +++
 rtl/data_mem_responder.sv | 128 ++++++++++++
 tb/tb_data_mem_responder.sv | 232 +++++++++++++++++++++++
 4 files changed

// File: rtl/data_mem_responder_pkg.sv
// Shared encodings and default sizes for the data-memory responder.
package data_mem_responder_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    WAIT = 2'b01,
    RESP = 2'b10
  } state_t;

  localparam int WAIT_CNT_W         = 4;
  localparam int DEFAULT_DEPTH      = 64;
  localparam int DEFAULT_DATA_WIDTH = 32;

endpackage

// File: rtl/data_mem_responder_dmem_array.sv
// Word storage for the responder: synchronous write, asynchronous read,
// synchronous active-low clear of every word.
module dmem_array
  import data_mem_responder_pkg::*;
#(
  parameter int DataWidth = DEFAULT_DATA_WIDTH,
  parameter int Depth     = DEFAULT_DEPTH,
  localparam int IdxW     = $clog2(Depth)
) (
  input  logic                 clk,
  input  logic                 RST,
  input  logic                 wr_en,
  input  logic [IdxW-1:0]      wr_idx,
  input  logic [DataWidth-1:0] wr_data,
  input  logic [IdxW-1:0]      rd_idx,
  output logic [DataWidth-1:0] rd_data
);

  logic [DataWidth-1:0] mem [Depth];

  always_ff @(posedge clk) begin
    if (!RST) begin
      for (int i = 0; i < Depth; i++) mem[i] <= '0;
    end else if (wr_en) begin
      mem[wr_idx] <= wr_data;
    end
  end

  assign rd_data = mem[rd_idx];

endmodule

// File: rtl/data_mem_responder.sv
// Load/store responder with a fixed number of wait states per transaction.
// Request and response both use valid/ready: a transfer happens on a rising edge where valid and ready are both high.
module data_mem_responder
  import data_mem_responder_pkg::*;
#(
  parameter int DataWidth  = DEFAULT_DATA_WIDTH,
  parameter int Depth      = DEFAULT_DEPTH,
  parameter int WaitStates = 2
) (
  input  logic                 clk,
  input  logic                 RST,
  input  logic                 Req_Valid,
  output logic                 Req_Ready,
  input  logic                 Req_Write,
  input  logic [DataWidth-1:0] Req_Addr,
  input  logic [DataWidth-1:0] Req_WData,
  output logic                 Resp_Valid,
  input  logic                 Resp_Ready,
  output logic [DataWidth-1:0] Resp_RData,
  output logic                 Resp_Err,
  output logic                 Busy
);

  localparam int IdxW = $clog2(Depth);

  state_t                  state, state_next;
  logic [WAIT_CNT_W-1:0]   cnt, cnt_next;
  logic                    commit;

  logic                    lat_write, lat_err;
  logic [IdxW-1:0]         lat_idx;
  logic [DataWidth-1:0]    lat_wdata;

  logic                    req_err;
  logic                    cur_write, cur_err;
  logic [IdxW-1:0]         cur_idx;
  logic [DataWidth-1:0]    cur_wdata, arr_rdata;

  logic [DataWidth-1:0]    rdata_q;
  logic                    err_q;

  // Index bits above Depth-1 are an error rather than an alias.
  assign req_err = (Req_Addr[1:0] != 2'b00) | (Req_Addr[DataWidth-1:IdxW+2] != '0);

  // With zero wait states the commit happens on the accepting edge itself,
  // so the live request fields are used instead of the latched copy.
  assign cur_write = (state == IDLE) ? Req_Write         : lat_write;
  assign cur_err   = (state == IDLE) ? req_err           : lat_err;
  assign cur_idx   = (state == IDLE) ? Req_Addr[IdxW+1:2] : lat_idx;
  assign cur_wdata = (state == IDLE) ? Req_WData         : lat_wdata;

  always_comb begin
    state_next = state;
    cnt_next   = cnt;
    commit     = 1'b0;
    case (state)
      IDLE: begin
        if (Req_Valid) begin
          if (WaitStates > 0) begin
            state_next = WAIT;
            cnt_next   = WAIT_CNT_W'(WaitStates - 1);
          end else begin
            state_next = RESP;
            commit     = 1'b1;
          end
        end
      end
      WAIT: begin
        if (cnt == '0) begin
          state_next = RESP;
          commit     = 1'b1;
        end else begin
          cnt_next = cnt - 1'b1;
        end
      end
      RESP: begin
        if (Resp_Ready) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!RST) begin
      state     <= IDLE;
      cnt       <= '0;
      lat_write <= 1'b0;
      lat_err   <= 1'b0;
      lat_idx   <= '0;
      lat_wdata <= '0;
      rdata_q   <= '0;
      err_q     <= 1'b0;
    end else begin
      state <= state_next;
      cnt   <= cnt_next;
      if (state == IDLE && Req_Valid) begin
        lat_write <= Req_Write;
        lat_err   <= req_err;
        lat_idx   <= Req_Addr[IdxW+1:2];
        lat_wdata <= Req_WData;
      end
      if (commit) begin
        rdata_q <= (cur_write | cur_err) ? '0 : arr_rdata;
        err_q   <= cur_err;
      end
    end
  end

  dmem_array #(
    .DataWidth(DataWidth),
    .Depth    (Depth)
  ) u_array (
    .clk    (clk),
    .RST    (RST),
    .wr_en  (commit & cur_write & ~cur_err),
    .wr_idx (cur_idx),
    .wr_data(cur_wdata),
    .rd_idx (cur_idx),
    .rd_data(arr_rdata)
  );

  assign Req_Ready  = (state == IDLE);
  assign Resp_Valid = (state == RESP);
  assign Busy       = (state != IDLE);
  assign Resp_RData = rdata_q;
  assign Resp_Err   = err_q;

endmodule

// File: tb/tb_data_mem_responder.sv
// Bench for data_mem_responder: a word-array model checked every cycle on a
// two-wait-state instance, plus directed checks on a zero-wait-state instance.
module tb_data_mem_responder;

  localparam int WS = 2;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid, req_ready, req_write, resp_valid, resp_ready, resp_err, busy;
  logic [31:0] req_addr, req_wdata, resp_rdata;
  logic        z_req_valid, z_req_ready, z_req_write, z_resp_valid, z_resp_ready, z_resp_err, z_busy;
  logic [31:0] z_req_addr, z_req_wdata, z_resp_rdata;

  int total = 0;
  int bad   = 0;

  data_mem_responder #(.DataWidth(32), .Depth(64), .WaitStates(WS)) u_dut (
    .clk(clk), .RST(rst),
    .Req_Valid(req_valid), .Req_Ready(req_ready), .Req_Write(req_write),
    .Req_Addr(req_addr), .Req_WData(req_wdata),
    .Resp_Valid(resp_valid), .Resp_Ready(resp_ready),
    .Resp_RData(resp_rdata), .Resp_Err(resp_err), .Busy(busy)
  );

  data_mem_responder #(.DataWidth(32), .Depth(64), .WaitStates(0)) u_dut_ws0 (
    .clk(clk), .RST(rst),
    .Req_Valid(z_req_valid), .Req_Ready(z_req_ready), .Req_Write(z_req_write),
    .Req_Addr(z_req_addr), .Req_WData(z_req_wdata),
    .Resp_Valid(z_resp_valid), .Resp_Ready(z_resp_ready),
    .Resp_RData(z_resp_rdata), .Resp_Err(z_resp_err), .Busy(z_busy)
  );

  // clock
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", name, got, exp);
    end
  endtask

  task automatic chk_b(input string name, input logic got, input logic exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%b exp=%b", name, got, exp);
    end
  endtask

  // Behavioural model: one outstanding request, response due WS+1 cycles after
  // acceptance, memory updated only when the response becomes due.
  logic [31:0] mem_m [64];
  bit          live = 0, pend = 0, resolved = 0, chk_rst = 0;
  int          age = 0;
  int          idx;
  logic        p_w, e_err;
  logic [31:0] p_a, p_d, e_rd;

  always @(negedge clk) begin
    if (live) begin
      if (pend && age == WS && !resolved) begin
        resolved = 1;
        e_err = ((p_a % 4) != 0) || ((p_a / 4) >= 64);
        e_rd  = 32'h0;
        if (!e_err) begin
          idx = int'(p_a / 4);
          if (p_w) mem_m[idx] = p_d;
          else     e_rd = mem_m[idx];
        end
      end
      chk_b("m_resp_valid", resp_valid, pend && age >= WS);
      chk_b("m_req_ready", req_ready, !pend);
      chk_b("m_busy", busy, pend);
      if (pend && age >= WS) begin
        chk("m_resp_rdata", resp_rdata, e_rd);
        chk_b("m_resp_err", resp_err, e_err);
      end
      if (chk_rst) begin
        chk("m_rst_rdata", resp_rdata, 32'h0);
        chk_b("m_rst_err", resp_err, 1'b0);
        chk_rst = 0;
      end
    end
    // predict the effect of the coming rising edge
    if (!rst) begin
      live = 1; pend = 0; resolved = 0; chk_rst = 1;
      for (int i = 0; i < 64; i++) mem_m[i] = 32'h0;
    end else if (live) begin
      if (!pend) begin
        if (req_valid) begin
          pend = 1; age = 0; resolved = 0;
          p_w = req_write; p_a = req_addr; p_d = req_wdata;
        end
      end else if (age < WS) begin
        age++;
      end else if (resp_ready) begin
        pend = 0;
      end
    end
  end

  // driver: one transaction on the WS=2 instance; called and returns at posedge+1
  task automatic do_txn(input logic w, input logic [31:0] a, input logic [31:0] d, input int hold,
                        output int lat, output logic [31:0] rd, output logic er);
    int k = 0;
    while (req_ready !== 1'b1 && k < 50) begin @(posedge clk); #1; k++; end
    if (k >= 50) begin total++; bad++; $display("FAIL req_ready_timeout addr=%h", a); end
    req_valid = 1'b1; req_write = w; req_addr = a; req_wdata = d; resp_ready = (hold == 0);
    @(posedge clk); #1;
    req_valid = 1'b0; req_write = 1'($urandom_range(0, 1));
    req_addr = $urandom; req_wdata = $urandom;
    lat = 1;
    while (resp_valid !== 1'b1 && lat < 40) begin @(posedge clk); #1; lat++; end
    if (lat >= 40) begin total++; bad++; $display("FAIL resp_valid_timeout addr=%h", a); end
    rd = resp_rdata; er = resp_err;
    for (int i = 0; i < hold; i++) begin
      req_valid = (i == 1); req_write = 1'b1; req_addr = 32'h0; req_wdata = 32'hFFFF_FFFF;
      @(posedge clk); #1;
    end
    req_valid = 1'b0; resp_ready = 1'b1;
    @(posedge clk); #1;
    resp_ready = 1'b0;
  endtask

  logic [31:0] v_addr [7] = '{32'h10, 32'h3C, 32'hF8, 32'h101, 32'h200, 32'h8000_0000, 32'h2};
  logic        v_err  [7] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1};

  initial begin
    int lat, n_acc;
    logic [31:0] rd, val;
    logic er;
    rst = 1'b0; req_valid = 1'b0; req_write = 1'b0; req_addr = '0; req_wdata = '0; resp_ready = 1'b0;
    z_req_valid = 1'b0; z_req_write = 1'b0; z_req_addr = '0; z_req_wdata = '0; z_resp_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk_b("rst_req_ready", req_ready, 1'b1);
    chk_b("rst_resp_valid", resp_valid, 1'b0);
    chk_b("rst_busy", busy, 1'b0);
    chk("rst_rdata", resp_rdata, 32'h0);
    chk_b("rst_err", resp_err, 1'b0);
    rst = 1'b1;

    // zero wait states: response in the cycle after acceptance
    chk_b("z_rst_req_ready", z_req_ready, 1'b1);
    z_req_valid = 1'b1; z_req_write = 1'b1; z_req_addr = 32'h10; z_req_wdata = 32'h55; z_resp_ready = 1'b1;
    @(posedge clk); #1;
    chk_b("z_st_valid", z_resp_valid, 1'b1);
    chk_b("z_st_req_ready", z_req_ready, 1'b0);
    chk("z_st_rdata", z_resp_rdata, 32'h0);
    chk_b("z_st_err", z_resp_err, 1'b0);
    z_req_write = 1'b0;
    @(posedge clk); #1;
    chk_b("z_hs_valid", z_resp_valid, 1'b0);
    chk_b("z_hs_req_ready", z_req_ready, 1'b1);
    @(posedge clk); #1;
    chk_b("z_ld_valid", z_resp_valid, 1'b1);
    chk("z_ld_rdata", z_resp_rdata, 32'h55);
    n_acc = 0;
    for (int i = 0; i < 8; i++) begin
      if (z_req_ready) n_acc++;
      @(posedge clk); #1;
    end
    chk("z_b2b_accepts", 32'(n_acc), 32'd4);
    z_req_valid = 1'b0;

    // store then load with two wait states
    do_txn(1'b1, 32'h8, 32'hDEAD_BEEF, 0, lat, rd, er);
    chk("st8_lat", 32'(lat), 32'd3); chk("st8_rdata", rd, 32'h0); chk_b("st8_err", er, 1'b0);
    do_txn(1'b0, 32'h8, 32'h0, 0, lat, rd, er);
    chk("ld8_lat", 32'(lat), 32'd3); chk("ld8_rdata", rd, 32'hDEAD_BEEF); chk_b("ld8_err", er, 1'b0);
    do_txn(1'b0, 32'h6, 32'h0, 0, lat, rd, er);
    chk("ld6_rdata", rd, 32'h0); chk_b("ld6_err", er, 1'b1);
    do_txn(1'b1, 32'h100, 32'h77, 0, lat, rd, er);
    chk_b("st100_err", er, 1'b1); chk("st100_rdata", rd, 32'h0);
    do_txn(1'b0, 32'h0, 32'h0, 0, lat, rd, er);
    chk("ld0_rdata", rd, 32'h0); chk_b("ld0_err", er, 1'b0);

    // last word, and neighbouring words stay independent
    do_txn(1'b1, 32'hFC, 32'hA5A5_A5A5, 0, lat, rd, er);
    do_txn(1'b0, 32'hFC, 32'h0, 0, lat, rd, er);
    chk("ldfc_rdata", rd, 32'hA5A5_A5A5); chk_b("ldfc_err", er, 1'b0);
    do_txn(1'b1, 32'h4, 32'h0BAD_F00D, 0, lat, rd, er);
    do_txn(1'b1, 32'h0, 32'h1, 0, lat, rd, er);

    // stalled response with a stray request pulse that must be ignored
    do_txn(1'b0, 32'h8, 32'h0, 5, lat, rd, er);
    chk("hold_rdata", rd, 32'hDEAD_BEEF); chk_b("hold_err", er, 1'b0);
    do_txn(1'b0, 32'h4, 32'h0, 0, lat, rd, er);
    chk("ld4_rdata", rd, 32'h0BAD_F00D);
    do_txn(1'b0, 32'h0, 32'h0, 0, lat, rd, er);
    chk("ld0b_rdata", rd, 32'h1);

    // address table: store then load each entry
    for (int i = 0; i < 7; i++) begin
      val = 32'hC0DE_0000 | 32'(i);
      do_txn(1'b1, v_addr[i], val, 0, lat, rd, er);
      chk_b("tbl_st_err", er, v_err[i]); chk("tbl_st_rdata", rd, 32'h0);
      do_txn(1'b0, v_addr[i], 32'h0, 0, lat, rd, er);
      chk_b("tbl_ld_err", er, v_err[i]); chk("tbl_ld_rdata", rd, v_err[i] ? 32'h0 : val);
    end

    // reset while a store is waiting
    req_valid = 1'b1; req_write = 1'b1; req_addr = 32'h4; req_wdata = 32'h1234_5678;
    @(posedge clk); #1;
    req_valid = 1'b0;
    chk_b("mid_busy_before", busy, 1'b1);
    rst = 1'b0;
    @(posedge clk); #1;
    chk_b("mid_busy_after", busy, 1'b0);
    chk_b("mid_req_ready", req_ready, 1'b1);
    chk_b("mid_resp_valid", resp_valid, 1'b0);
    rst = 1'b1;
    do_txn(1'b0, 32'h4, 32'h0, 0, lat, rd, er);
    chk("mid_ld4_rdata", rd, 32'h0);
    do_txn(1'b0, 32'h8, 32'h0, 0, lat, rd, er);
    chk("mid_ld8_rdata", rd, 32'h0);

    repeat (3) @(posedge clk);
    #1;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog expired");
  end

endmodule
